// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble/hold modes and multi-cycle scratch feedback; optional perf counters under PIPE_STAGE_REG_PERF_EN.
// Latency: one cycle in_* -> out_*, all outputs registered. Backpressure: stall[STAGE] holds or bubbles, stall[STAGE+1] selects which.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int TMP_W   = 64,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [TMP_W-1:0]   tmp_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [TMP_W-1:0]   tmp_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [PERF_W-1:0]  perf_stall,
    output logic [PERF_W-1:0]  perf_bubble,
    output logic [PERF_W-1:0]  perf_flush
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TMP_W-1:0]   tmp_q, tmp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic mode_adv, mode_bubble;

    assign mode_adv    = !stall[STAGE];
    assign mode_bubble = stall[STAGE] && !stall[STAGE+1];

    // Scratch is only echoed back during a bubble; every other mode clears it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tmp_d   = '0;
        cnt_d   = '0;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (mode_adv) begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : '0;
        end else if (mode_bubble) begin
            valid_d = 1'b0;
            data_d  = '0;
            tmp_d   = tmp_i;
            cnt_d   = cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tmp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tmp_q   <= tmp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign tmp_o     = tmp_q;
    assign cnt_o     = cnt_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [PERF_W-1:0] pstall_q, pstall_d;
    logic [PERF_W-1:0] pbub_q, pbub_d;
    logic [PERF_W-1:0] pflush_q, pflush_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        pstall_d = pstall_q;
        pbub_d   = pbub_q;
        pflush_d = pflush_q;
        if (flush) begin
            if (pflush_q != '1) pflush_d = pflush_q + 1'b1;
        end else if (!mode_adv) begin
            if (pstall_q != '1) pstall_d = pstall_q + 1'b1;
            if (mode_bubble && (pbub_q != '1)) pbub_d = pbub_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstall_q <= '0;
            pbub_q   <= '0;
            pflush_q <= '0;
        end else begin
            pstall_q <= pstall_d;
            pbub_q   <= pbub_d;
            pflush_q <= pflush_d;
        end
    end

    assign perf_stall  = pstall_q;
    assign perf_bubble = pbub_q;
    assign perf_flush  = pflush_q;
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
    assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a cycle model checked every cycle plus literal expectations.
module tb_pipe_stage_reg;
    localparam int DATA_W  = 8;
    localparam int TMP_W   = 64;
    localparam int CNT_W   = 2;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int PERF_W  = 4;
`ifdef PIPE_STAGE_REG_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [TMP_W-1:0]   tmp_i;
    logic [CNT_W-1:0]   cnt_i;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [TMP_W-1:0]   tmp_o;
    logic [CNT_W-1:0]   cnt_o;
    logic [PERF_W-1:0]  perf_stall, perf_bubble, perf_flush;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .TMP_W(TMP_W), .CNT_W(CNT_W),
        .STALL_W(STALL_W), .STAGE(STAGE), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .tmp_i(tmp_i), .cnt_i(cnt_i),
        .out_valid(out_valid), .out_data(out_data), .tmp_o(tmp_o), .cnt_o(cnt_o),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    // Model state: what each output must hold after the latest edge.
    bit          m_known = 1'b0;
    bit          m_valid;
    int unsigned m_data;
    logic [63:0] m_tmp;
    int unsigned m_cnt;
    int unsigned m_ps, m_pb, m_pf;
    localparam int unsigned PMAX = (1 << PERF_W) - 1;

    always @(posedge clk) begin
        bit stalled, downstream_stalled;
        stalled            = stall[STAGE];
        downstream_stalled = stall[STAGE+1];
        if (rst) begin
            m_known = 1'b1;
            m_valid = 0; m_data = 0; m_tmp = 0; m_cnt = 0;
            m_ps = 0; m_pb = 0; m_pf = 0;
        end else if (flush) begin
            m_valid = 0; m_data = 0; m_tmp = 0; m_cnt = 0;
            if (m_pf < PMAX) m_pf++;
        end else if (!stalled) begin
            m_valid = in_valid;
            m_data  = in_valid ? in_data : 0;
            m_tmp = 0; m_cnt = 0;
        end else begin
            if (m_ps < PMAX) m_ps++;
            if (!downstream_stalled) begin
                m_valid = 0; m_data = 0;
                m_tmp = tmp_i; m_cnt = cnt_i;
                if (m_pb < PMAX) m_pb++;
            end else begin
                m_tmp = 0; m_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            check("model.out_valid", 64'(out_valid), 64'(m_valid));
            check("model.out_data", 64'(out_data), 64'(m_data));
            check("model.tmp_o", tmp_o, m_tmp);
            check("model.cnt_o", 64'(cnt_o), 64'(m_cnt));
            check("model.perf_stall", 64'(perf_stall), PERF_ON ? 64'(m_ps) : 64'd0);
            check("model.perf_bubble", 64'(perf_bubble), PERF_ON ? 64'(m_pb) : 64'd0);
            check("model.perf_flush", 64'(perf_flush), PERF_ON ? 64'(m_pf) : 64'd0);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0;
        in_valid = 1'b1; in_data = 8'hA5; tmp_i = 64'hDEAD; cnt_i = 2'd3;
        step();
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_data", 64'(out_data), 64'd0);
        check("reset.tmp_o", tmp_o, 64'd0);
        check("reset.perf_stall", 64'(perf_stall), 64'd0);

        rst = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        step();
        check("adv.out_valid", 64'(out_valid), 64'd1);
        check("adv.out_data", 64'(out_data), 64'h3C);
        check("adv.tmp_o", tmp_o, 64'd0);
        in_valid = 1'b0; in_data = 8'hFF;
        step();
        check("adv_invalid.out_valid", 64'(out_valid), 64'd0);
        check("adv_invalid.out_data", 64'(out_data), 64'd0);

        // Bubble twice with the same scratch, then release.
        stall = 6'b001000; tmp_i = 64'h1234; cnt_i = 2'd1; in_valid = 1'b1; in_data = 8'h11;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bubble.out_valid", 64'(out_valid), 64'd0);
            check("bubble.tmp_o", tmp_o, 64'h1234);
            check("bubble.cnt_o", 64'(cnt_o), 64'd1);
        end
        stall = '0; in_data = 8'h77;
        step();
        check("unbubble.tmp_o", tmp_o, 64'd0);
        check("unbubble.cnt_o", 64'(cnt_o), 64'd0);
        check("unbubble.out_data", 64'(out_data), 64'h77);

        // Back-to-back bubbles with changing scratch.
        stall = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            tmp_i = 64'hF0F0_0000_0000_0000 + 64'(i * 7);
            cnt_i = CNT_W'(i + 1);
            step();
        end
        check("bubble_seq.tmp_o", tmp_o, 64'hF0F0_0000_0000_000E);
        check("bubble_seq.cnt_o", 64'(cnt_o), 64'd3);

        // Hold keeps the payload while upstream keeps changing.
        stall = '0; in_valid = 1'b1; in_data = 8'h55;
        step();
        stall = 6'b011000; in_data = 8'hAA; tmp_i = 64'h9999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold.out_data", 64'(out_data), 64'h55);
            check("hold.out_valid", 64'(out_valid), 64'd1);
            check("hold.tmp_o", tmp_o, 64'd0);
        end
        stall = '1;
        step();
        check("all_ones.out_data", 64'(out_data), 64'h55);

        // A downstream-only stall does not stop this stage.
        stall = 6'b010000; in_data = 8'h42;
        step();
        check("downstream_only.out_data", 64'(out_data), 64'h42);

        // Flush during a would-be bubble.
        stall = 6'b001000; tmp_i = 64'hCAFE; cnt_i = 2'd2; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.tmp_o", tmp_o, 64'd0);
        check("flush.perf_flush", 64'(perf_flush), PERF_ON ? 64'd1 : 64'd0);

        // Reset in the middle of a bubble sequence discards the scratch.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_bubble.tmp_o", tmp_o, 64'd0);
        check("rst_mid_bubble.cnt_o", 64'(cnt_o), 64'd0);

        // Long hold saturates the stall counter.
        stall = 6'b011000;
        for (int i = 0; i < 20; i++) step();
        check("saturate.perf_stall", 64'(perf_stall), PERF_ON ? 64'hF : 64'd0);
        check("saturate.perf_bubble", 64'(perf_bubble), 64'd0);

        stall = '0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (range 1..512).
REQ-002 SHALL have parameter TMP_W, default 64, multi-cycle scratch width in bits (range 1..128).
REQ-003 SHALL have parameter CNT_W, default 2, multi-cycle step counter width in bits (range 1..8).
REQ-004 SHALL have parameter STALL_W, default 6, stall vector width; parameter STAGE, default 3, this register's stall index (range 0..STALL_W-2).
REQ-005 SHALL have parameter PERF_W, default 32, performance counter width in bits.
REQ-006 SHALL have ports, one per line:
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  pipeline stall vector.
- flush  in  1  kill this stage's contents (exception/redirect).
- in_valid  in  1  upstream slot holds a real instruction.
- in_data  in  DATA_W  packed upstream payload.
- tmp_i  in  TMP_W  multi-cycle scratch from upstream.
- cnt_i  in  CNT_W  multi-cycle step from upstream.
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered payload.
- tmp_o  out  TMP_W  scratch fed back upstream.
- cnt_o  out  CNT_W  step fed back upstream.
- perf_stall  out  PERF_W  stall-cycle counter.
- perf_bubble  out  PERF_W  bubble-insert counter.
- perf_flush  out  PERF_W  flush counter.

Function
REQ-007 SHALL decode the mode each cycle: ADVANCE = !stall[STAGE]; BUBBLE = stall[STAGE] && !stall[STAGE+1]; HOLD = stall[STAGE] && stall[STAGE+1].
REQ-008 SHALL apply priority rst > flush > ADVANCE/BUBBLE/HOLD; all registers update only on posedge clk.
REQ-009 ADVANCE SHALL load out_valid<=in_valid, out_data<=(in_valid ? in_data : 0), tmp_o<=0, cnt_o<=0.
REQ-010 BUBBLE SHALL load out_valid<=0, out_data<=0, tmp_o<=tmp_i, cnt_o<=cnt_i, so the upstream multi-cycle unit receives its state back the next cycle.
REQ-011 HOLD SHALL keep out_valid and out_data unchanged and clear tmp_o and cnt_o.
REQ-012 flush=1 SHALL clear out_valid, out_data, tmp_o and cnt_o regardless of stall.
REQ-013 Latency SHALL be exactly one cycle from in_* to out_* in ADVANCE; out_* SHALL never be combinationally dependent on any input.
REQ-014 Back-to-back BUBBLE cycles SHALL pass tmp_i/cnt_i every cycle; scratch content SHALL not be interpreted or modified.
REQ-015 An ADVANCE following a BUBBLE sequence SHALL clear tmp_o/cnt_o in the same edge as the payload loads.
REQ-016 An all-ones stall vector SHALL behave as HOLD; an all-zero stall vector SHALL behave as ADVANCE.

Reset
REQ-017 rst SHALL clear out_valid, out_data, tmp_o, cnt_o and all three perf counters to 0 on the next posedge clk.
REQ-018 rst asserted mid multi-cycle operation (BUBBLE) SHALL discard the scratch; tmp_o=0 and cnt_o=0 the cycle after.

Configuration
REQ-019 Macro PIPE_STAGE_REG_PERF_EN SHALL compile in the performance counters.
REQ-020 With PIPE_STAGE_REG_PERF_EN: perf_stall increments on each BUBBLE or HOLD cycle without flush; perf_bubble increments on each BUBBLE cycle without flush; perf_flush increments on each flush cycle; all saturate at all-ones (no wrap).
REQ-021 Without PIPE_STAGE_REG_PERF_EN: perf ports SHALL remain present and be constant 0, and no counter flops SHALL be inferred.

Verification
REQ-022 Reset: rst=1 one cycle with DATA_W=8, in_data=8'hA5, in_valid=1 -> all outputs 0 the cycle after.
REQ-023 Advance: stall=0, in_valid=1, in_data=8'h3C -> out_valid=1, out_data=8'h3C next cycle; in_valid=0, in_data=8'hFF -> out_data=0.
REQ-024 Bubble: stall=6'b001000, tmp_i=64'h1234, cnt_i=2'd1 for 2 cycles -> out_valid=0, tmp_o=64'h1234, cnt_o=1 each cycle; then stall=0 -> tmp_o=0, cnt_o=0.
REQ-025 Hold: out_data=8'h55 valid, stall=6'b011000 for 3 cycles with in_data=8'hAA -> out_data stays 8'h55, tmp_o=0.
REQ-026 Flush: flush=1 with stall=6'b001000, tmp_i nonzero -> out_valid=0, tmp_o=0; with PERF_EN, perf_flush=1 and perf_bubble unchanged.
REQ-027 Saturation: PERF_EN, PERF_W=4, HOLD for 20 cycles -> perf_stall=4'hF, not wrapped.
